seq_detect_param: RTL and testbench

//  Parametrised, runtime-programmable Mealy serial-sequence detector; next generation of the fixed 5-bit detectors.

---
 rtl/seq_detect_param.sv | 116 +++++++++++
 tb/tb_seq_detect_param.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Runtime-programmable Mealy serial-sequence detector with overlap/non-overlap modes
// and a saturating match counter.
module seq_detect_param #(
  parameter int               PAT_W   = 5,
  parameter int               LEN_W   = $clog2(PAT_W) + 1,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = 5'b10101,
  parameter int               DEF_LEN = 5,
  parameter bit               DEF_OVL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_W-2:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PAT_W-1:0] window;
  logic [PAT_W-1:0] mask;
  logic             pat_hit;
  logic             fill_ok;
  logic [LEN_W-1:0] len_clamped;

  // Window holds the newest PAT_W bits with din at bit 0, so it lines up with pat[len-1:0].
  assign window = {hist_q, din};

  genvar gi;
  generate
    for (gi = 0; gi < PAT_W; gi++) begin : g_mask
      assign mask[gi] = (LEN_W'(gi) < len_q);
    end
  endgenerate

  assign pat_hit = (((window ^ pat_q) & mask) == '0);
  assign fill_ok = (fill_q >= (len_q - LEN_W'(1)));
  assign dout    = en & ~rst & ~cfg_load & fill_ok & pat_hit;

  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len == '0) begin
      len_clamped = LEN_W'(1);
    end else if (cfg_len > LEN_MAX) begin
      len_clamped = LEN_MAX;
    end
  end

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    if (cfg_load) begin
      pat_d  = cfg_pattern;
      len_d  = len_clamped;
      ovl_d  = cfg_overlap;
      fill_d = '0;
    end else if (en) begin
      hist_d = window[PAT_W-2:0];
      if (dout && !ovl_q) begin
        fill_d = '0;
      end else if (fill_q < len_q) begin
        fill_d = fill_q + LEN_W'(1);
      end else begin
        fill_d = len_q;
      end
    end
  end

  // Clear beats a coincident match; the counter never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (dout && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= DEF_PAT;
      len_q  <= LEN_W'(DEF_LEN);
      ovl_q  <= DEF_OVL;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      cnt_q  <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: a bit-queue reference model pushes expected
// results to a scoreboard; two instances (CNT_W=8 and CNT_W=2) share all stimulus.
module tb_seq_detect_param;

  localparam int PAT_W = 5;
  localparam int LEN_W = $clog2(PAT_W) + 1;

  logic             clk = 1'b0;
  logic             rst, en, din, cfg_load, cfg_overlap, cnt_clr;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             dout8, dout2;
  logic [7:0]       cnt8;
  logic [1:0]       cnt2;

  always #5 clk = ~clk;

  seq_detect_param #(.CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .din(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .dout(dout8), .match_cnt(cnt8)
  );

  seq_detect_param #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .din(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .dout(dout2), .match_cnt(cnt2)
  );

  typedef struct {
    logic       dout;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: the raw bits received since the last reset/load/non-overlap match.
  bit         mq[$];
  bit [4:0]   m_pat;
  int         m_len;
  bit         m_ovl;
  int         m_cnt8, m_cnt2;

  int vectors = 0;
  int miscompares = 0;
  int step_no = 0;

  function automatic bit model_step(input bit rs, input bit e, input bit d,
                                    input bit ld, input bit clr);
    bit hit;
    hit = 1'b0;
    if (rs) begin
      mq.delete();
      m_pat = 5'b10101; m_len = 5; m_ovl = 1'b0;
    end else if (ld) begin
      mq.delete();
      m_pat = cfg_pattern;
      m_ovl = cfg_overlap;
      m_len = (cfg_len == 0) ? 1 : ((int'(cfg_len) > PAT_W) ? PAT_W : int'(cfg_len));
    end else if (e) begin
      mq.push_back(d);
      if (mq.size() >= m_len) begin
        hit = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (mq[mq.size() - 1 - i] != m_pat[i]) hit = 1'b0;
      end
      if (hit && !m_ovl) mq.delete();
      while (mq.size() > PAT_W) void'(mq.pop_front());
    end
    if (rs || clr) begin
      m_cnt8 = 0; m_cnt2 = 0;
    end else if (hit) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    return hit;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s step %0d: observed %0h expected %0h", tag, step_no, obs, expv);
    end
  endtask

  // One clock: drive, push expectation, sample dout mid-cycle, compare counters after the edge.
  task automatic step(input bit rs, input bit e, input bit d, input bit ld, input bit clr);
    exp_t x, y;
    logic s_d8, s_d2;
    rst = rs; en = e; din = d; cfg_load = ld; cnt_clr = clr;
    x.dout = model_step(rs, e, d, ld, clr);
    x.cnt8 = 8'(m_cnt8);
    x.cnt2 = 2'(m_cnt2);
    exp_q.push_back(x);
    #3;
    s_d8 = dout8; s_d2 = dout2;
    @(posedge clk); #1;
    step_no++;
    y = exp_q.pop_front();
    check("dout8", {7'd0, s_d8}, {7'd0, y.dout});
    check("dout2", {7'd0, s_d2}, {7'd0, y.dout});
    check("cnt8", cnt8, y.cnt8);
    check("cnt2", {6'd0, cnt2}, {6'd0, y.cnt2});
    $display("step %0d rst=%0b en=%0b din=%0b ld=%0b clr=%0b dout=%0b cnt8=%0d cnt2=%0d",
             step_no, rs, e, d, ld, clr, s_d8, cnt8, cnt2);
  endtask

  task automatic stream(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, bits[i], 1'b0, 1'b0);
  endtask

  task automatic load(input logic [4:0] p, input logic [3:0] l, input bit o);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; din = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    m_pat = 5'b10101; m_len = 5; m_ovl = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
    @(posedge clk); #1;

    // Reset defaults, non-overlapping 10101
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    stream(32'b1010101010101, 13);

    // Overlapping mode, same stream; counter keeps running across the load
    load(5'b10101, 4'd5, 1'b1);
    stream(32'b1010101010101, 13);

    // 3-bit pattern 110 with two idle cycles inside the stream
    load(5'b00110, 4'd3, 1'b0);
    stream(32'b1101, 4);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    stream(32'b101110, 6);

    // cfg_len=0 behaves as length 1; cfg_len=7 behaves as length 5
    load(5'b11101, 4'd0, 1'b0);
    stream(32'b101, 3);
    load(5'b10101, 4'd7, 1'b0);
    stream(32'b1101011, 7);

    // Counter clear, saturation of the narrow counter, clear coincident with a match
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    load(5'b00001, 4'd1, 1'b1);
    stream(32'b11111, 5);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    stream(32'b1, 1);

    // Reset mid-pattern, then full pattern, then load coincident with the final bit
    load(5'b10101, 4'd5, 1'b0);
    stream(32'b1010, 4);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    stream(32'b1, 1);
    stream(32'b10101, 5);
    stream(32'b1010, 4);
    cfg_pattern = 5'b10101; cfg_len = 4'd5; cfg_overlap = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    stream(32'b1, 1);

    // Random traffic in overlapping mode with a 4-bit pattern
    load(5'b01011, 4'd4, 1'b1);
    for (int i = 0; i < 60; i++)
      step(1'b0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
